// File: rtl/game_sequencer.sv
// Flappy Bird game flow controller: input debounce, idle/play/dying/over sequencing, score keeping.
// Optional AUTO_RESTART_EN: OVER returns to IDLE after RESTART_FRAMES frame ticks without a press.
module game_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned DEATH_FRAMES    = 60,
  parameter int unsigned SCORE_W         = 7,
  parameter int unsigned RESTART_FRAMES  = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_raw,
  input  logic               frame_tick,
  input  logic               collision,
  input  logic               pipe_passed,
  output logic [1:0]         state,
  output logic               run,
  output logic               flap,
  output logic               game_rst,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]         DEATH_INIT = 8'(DEATH_FRAMES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  if (DEBOUNCE_CYCLES < 2 || DEATH_FRAMES < 1 || DEATH_FRAMES > 255 ||
      RESTART_FRAMES < 1 || RESTART_FRAMES > 255) begin : g_param_check
    $error("game_sequencer: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_DYING = 2'b10,
    ST_OVER  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        sync_q;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              clean_q, clean_d;
  logic              clean_prev_q;
  logic              press_c;
  logic              pending_q, pending_d;
  logic [7:0]        death_q, death_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_score_q, high_score_d;
  logic              run_q, run_d;
  logic              flap_q, flap_d;
  logic              game_rst_q, game_rst_d;
`ifdef AUTO_RESTART_EN
  localparam logic [7:0] RESTART_LIMIT = 8'(RESTART_FRAMES);
  logic [7:0]        restart_q, restart_d;
`endif

  // Debounce: accept the synchronized level only after it has disagreed for DEBOUNCE_CYCLES cycles.
  always_comb begin
    clean_d  = clean_q;
    db_cnt_d = '0;
    if (sync_q[1] != clean_q) begin
      if (db_cnt_q == DB_LAST) begin
        clean_d = sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  assign press_c = clean_q & ~clean_prev_q;

  // Game flow next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    death_d      = death_q;
    score_d      = score_q;
    high_score_d = high_score_q;
    flap_d       = 1'b0;
    game_rst_d   = 1'b0;
`ifdef AUTO_RESTART_EN
    restart_d    = restart_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (press_c) begin
          state_d    = ST_PLAY;
          score_d    = '0;
          game_rst_d = 1'b1;
          pending_d  = 1'b0;
        end
      end
      ST_PLAY: begin
        if (pipe_passed && score_q != SCORE_MAX) begin
          score_d = score_q + SCORE_W'(1);
        end
        // Collision wins over any flap due on the same cycle.
        if (collision) begin
          state_d   = ST_DYING;
          death_d   = DEATH_INIT;
          pending_d = 1'b0;
        end else if (frame_tick && (pending_q || press_c)) begin
          flap_d    = 1'b1;
          pending_d = 1'b0;
        end else if (press_c) begin
          pending_d = 1'b1;
        end
      end
      ST_DYING: begin
        if (frame_tick) begin
          death_d = death_q - 8'd1;
          if (death_q == 8'd1) begin
            state_d = ST_OVER;
            if (score_q > high_score_q) begin
              high_score_d = score_q;
            end
`ifdef AUTO_RESTART_EN
            restart_d = '0;
`endif
          end
        end
      end
      ST_OVER: begin
`ifdef AUTO_RESTART_EN
        if (frame_tick) begin
          restart_d = restart_q + 8'd1;
        end
        if (press_c || (frame_tick && (restart_q + 8'd1) == RESTART_LIMIT)) begin
          state_d    = ST_IDLE;
          game_rst_d = 1'b1;
        end
`else
        if (press_c) begin
          state_d    = ST_IDLE;
          game_rst_d = 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    run_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sync_q       <= '0;
      db_cnt_q     <= '0;
      clean_q      <= 1'b0;
      clean_prev_q <= 1'b0;
      pending_q    <= 1'b0;
      death_q      <= '0;
      score_q      <= '0;
      high_score_q <= '0;
      run_q        <= 1'b0;
      flap_q       <= 1'b0;
      game_rst_q   <= 1'b0;
`ifdef AUTO_RESTART_EN
      restart_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[0], btn_raw};
      db_cnt_q     <= db_cnt_d;
      clean_q      <= clean_d;
      clean_prev_q <= clean_q;
      pending_q    <= pending_d;
      death_q      <= death_d;
      score_q      <= score_d;
      high_score_q <= high_score_d;
      run_q        <= run_d;
      flap_q       <= flap_d;
      game_rst_q   <= game_rst_d;
`ifdef AUTO_RESTART_EN
      restart_q    <= restart_d;
`endif
    end
  end

  assign state      = state_q;
  assign run        = run_q;
  assign flap       = flap_q;
  assign game_rst   = game_rst_q;
  assign score      = score_q;
  assign high_score = high_score_q;

endmodule
